// File: rtl/led_frame_tx.sv
// rtl/led_frame_tx.sv - fifo_led read-side consumer that serialises LED words onto a one-wire NRZ line.
// Pops LED_NUM words per frame, prefetching the next word so bit periods stay back to back.
module led_frame_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int LED_NUM    = 64,
  parameter int T_BIT      = 63,
  parameter int T0H        = 20,
  parameter int T1H        = 40,
  parameter int T_RST      = 15000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_empty,
  output logic                  led_dout,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int BCW = $clog2(T_BIT);
  localparam int BIW = $clog2(DATA_WIDTH);
  localparam int LCW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
  localparam int RCW = $clog2(T_RST + 1);

  localparam logic [BCW-1:0] C_BIT_END = BCW'(T_BIT - 1);
  localparam logic [BCW-1:0] C_PF_RD   = BCW'(T_BIT - 3);
  localparam logic [BCW-1:0] C_PF_CAP  = BCW'(T_BIT - 2);
  localparam logic [BCW-1:0] C_T0H     = BCW'(T0H);
  localparam logic [BCW-1:0] C_T1H     = BCW'(T1H);
  localparam logic [BIW-1:0] C_IDX_MSB = BIW'(DATA_WIDTH - 1);
  localparam logic [LCW-1:0] C_LED_END = LCW'(LED_NUM - 1);
  localparam logic [RCW-1:0] C_RST_END = RCW'(T_RST - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SHIFT, S_LATCH} state_t;

  state_t                r_state, w_state_n;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_n;
  logic [DATA_WIDTH-1:0] r_next, w_next_n;
  logic [BCW-1:0]        r_bit_cnt, w_bit_cnt_n;
  logic [BIW-1:0]        r_bit_idx, w_bit_idx_n;
  logic [LCW-1:0]        r_led_cnt, w_led_cnt_n;
  logic [RCW-1:0]        r_rst_cnt, w_rst_cnt_n;
  logic                  r_abort, w_abort_n;
  logic                  r_led, w_led_n;
  logic                  r_busy, w_busy_n;
  logic                  r_done, w_done_n;
  logic                  r_underrun, w_underrun_n;
  logic                  w_rd_en;
  logic                  w_last_word;
  logic                  w_pf_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_next     <= '0;
      r_bit_cnt  <= '0;
      r_bit_idx  <= '0;
      r_led_cnt  <= '0;
      r_rst_cnt  <= '0;
      r_abort    <= 1'b0;
      r_led      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_shift    <= w_shift_n;
      r_next     <= w_next_n;
      r_bit_cnt  <= w_bit_cnt_n;
      r_bit_idx  <= w_bit_idx_n;
      r_led_cnt  <= w_led_cnt_n;
      r_rst_cnt  <= w_rst_cnt_n;
      r_abort    <= w_abort_n;
      r_led      <= w_led_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_underrun <= w_underrun_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_shift_n    = r_shift;
    w_next_n     = r_next;
    w_bit_cnt_n  = r_bit_cnt;
    w_bit_idx_n  = r_bit_idx;
    w_led_cnt_n  = r_led_cnt;
    w_rst_cnt_n  = r_rst_cnt;
    w_abort_n    = r_abort;
    w_busy_n     = r_busy;
    w_done_n     = 1'b0;
    w_underrun_n = r_underrun;
    w_rd_en      = 1'b0;
    w_last_word  = (r_led_cnt == C_LED_END);
    w_pf_bit     = (r_bit_idx == '0) && !w_last_word;

    case (r_state)
      S_IDLE: begin
        if (frame_start) begin
          w_underrun_n = 1'b0;
          w_busy_n     = 1'b1;
          w_led_cnt_n  = '0;
          w_abort_n    = 1'b0;
          w_rst_cnt_n  = '0;
          if (rd_empty) begin
            w_underrun_n = 1'b1;
            w_state_n    = S_LATCH;
          end else begin
            w_state_n = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (rd_empty) begin
          w_underrun_n = 1'b1;
          w_state_n    = S_LATCH;
        end else begin
          w_rd_en   = 1'b1;
          w_state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        w_shift_n   = rd_data;
        w_bit_idx_n = C_IDX_MSB;
        w_bit_cnt_n = '0;
        w_state_n   = S_SHIFT;
      end
      S_SHIFT: begin
        // Prefetch early enough in the last bit that the next word is ready at the bit boundary.
        if (w_pf_bit && r_bit_cnt == C_PF_RD) begin
          if (rd_empty) begin
            w_underrun_n = 1'b1;
            w_abort_n    = 1'b1;
          end else begin
            w_rd_en = 1'b1;
          end
        end
        if (w_pf_bit && r_bit_cnt == C_PF_CAP && !r_abort) begin
          w_next_n = rd_data;
        end
        if (r_bit_cnt == C_BIT_END) begin
          w_bit_cnt_n = '0;
          if (r_bit_idx != '0) begin
            w_shift_n   = r_shift << 1;
            w_bit_idx_n = r_bit_idx - 1'b1;
          end else if (w_last_word || r_abort) begin
            w_rst_cnt_n = '0;
            w_state_n   = S_LATCH;
          end else begin
            w_shift_n   = r_next;
            w_bit_idx_n = C_IDX_MSB;
            w_led_cnt_n = r_led_cnt + 1'b1;
          end
        end else begin
          w_bit_cnt_n = r_bit_cnt + 1'b1;
        end
      end
      S_LATCH: begin
        if (r_rst_cnt == C_RST_END) begin
          w_done_n  = 1'b1;
          w_busy_n  = 1'b0;
          w_state_n = S_IDLE;
        end else begin
          w_rst_cnt_n = r_rst_cnt + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // Line level is registered from next-cycle values so it lines up with bit_cnt exactly.
    w_led_n = (w_state_n == S_SHIFT) &&
              (w_bit_cnt_n < (w_shift_n[DATA_WIDTH-1] ? C_T1H : C_T0H));
  end

  assign rd_en      = w_rd_en;
  assign led_dout   = r_led;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign underrun   = r_underrun;

endmodule
